packet_cutter_cfg_sched: RTL and testbench

PACKET_CUTTER_CFG_SCHED -- requirements
Module: packet_cutter_cfg_sched

---
 rtl/packet_cutter_cfg_sched.sv | 144 ++++++++++++++
 tb/tb_packet_cutter_cfg_sched.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/packet_cutter_cfg_sched.sv
// Configuration scheduler for the packet cutter: captures committed settings
// into a shadow copy and moves them to the active outputs only between
// packets. The stream is stalled for the single cycle in which the update
// happens.
module packet_cutter_cfg_sched #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32
) (
  input  logic                          axi_aclk,
  input  logic                          axi_reset,
  input  logic                          cfg_commit,
  input  logic                          cfg_cut_en,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] cfg_cut_words,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] cfg_cut_offset,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] cfg_cut_bytes,
  input  logic                          cfg_hash_en,
  input  logic                          s_axis_tvalid_in,
  input  logic                          s_axis_tlast,
  output logic                          s_axis_tready_out,
  output logic                          s_axis_tvalid_out,
  input  logic                          s_axis_tready_in,
  output logic                          cut_en,
  output logic                          hash_en,
  output logic [C_S_AXI_DATA_WIDTH-1:0] cut_words,
  output logic [C_S_AXI_DATA_WIDTH-1:0] cut_offset,
  output logic [C_S_AXI_DATA_WIDTH-1:0] cut_bytes,
  output logic                          cfg_busy,
  output logic                          cfg_applied,
  output logic [C_S_AXI_DATA_WIDTH-1:0] apply_cnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_EOP = 2'd1,
    APPLY    = 2'd2
  } state_t;

  state_t                        state_q;
  logic                          in_pkt_q;

  logic                          sh_cut_en_q;
  logic                          sh_hash_en_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] sh_cut_words_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] sh_cut_offset_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] sh_cut_bytes_q;

  logic                          act_cut_en_q;
  logic                          act_hash_en_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] act_cut_words_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] act_cut_offset_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] act_cut_bytes_q;
  logic                          applied_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] apply_cnt_q;

  logic                          beat;
  logic                          tlast_beat;
  logic                          gate;

  // Stream gating: the update cycle blocks handshakes in both directions.
  always_comb begin
    gate              = (state_q == APPLY);
    s_axis_tvalid_out = gate ? 1'b0 : s_axis_tvalid_in;
    s_axis_tready_out = gate ? 1'b0 : s_axis_tready_in;
    beat              = s_axis_tvalid_out & s_axis_tready_in;
    tlast_beat        = beat & s_axis_tlast;
  end

  // Packet position tracking and shadow capture (last commit wins).
  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      in_pkt_q        <= 1'b0;
      sh_cut_en_q     <= 1'b0;
      sh_hash_en_q    <= 1'b0;
      sh_cut_words_q  <= '0;
      sh_cut_offset_q <= '0;
      sh_cut_bytes_q  <= '0;
    end else begin
      if (beat) begin
        in_pkt_q <= ~s_axis_tlast;
      end
      if (cfg_commit) begin
        sh_cut_en_q     <= cfg_cut_en;
        sh_hash_en_q    <= cfg_hash_en;
        sh_cut_words_q  <= cfg_cut_words;
        sh_cut_offset_q <= cfg_cut_offset;
        sh_cut_bytes_q  <= cfg_cut_bytes;
      end
    end
  end

  // Apply scheduler with registered active settings, pulse and counter.
  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      state_q          <= IDLE;
      act_cut_en_q     <= 1'b0;
      act_hash_en_q    <= 1'b0;
      act_cut_words_q  <= '0;
      act_cut_offset_q <= '0;
      act_cut_bytes_q  <= '0;
      applied_q        <= 1'b0;
      apply_cnt_q      <= '0;
    end else begin
      applied_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cfg_commit) begin
            if (!in_pkt_q || tlast_beat) begin
              state_q <= APPLY;
            end else begin
              state_q <= WAIT_EOP;
            end
          end
        end
        WAIT_EOP: begin
          if (tlast_beat) begin
            state_q <= APPLY;
          end
        end
        APPLY: begin
          // A commit landing here updates the shadow on this same edge, so the
          // follow-up APPLY cycle picks up the newer values.
          act_cut_en_q     <= sh_cut_en_q;
          act_hash_en_q    <= sh_hash_en_q;
          act_cut_words_q  <= sh_cut_words_q;
          act_cut_offset_q <= sh_cut_offset_q;
          act_cut_bytes_q  <= sh_cut_bytes_q;
          applied_q        <= 1'b1;
          apply_cnt_q      <= apply_cnt_q + 1'b1;
          state_q          <= cfg_commit ? APPLY : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cut_en      = act_cut_en_q;
  assign hash_en     = act_hash_en_q;
  assign cut_words   = act_cut_words_q;
  assign cut_offset  = act_cut_offset_q;
  assign cut_bytes   = act_cut_bytes_q;
  assign cfg_applied = applied_q;
  assign apply_cnt   = apply_cnt_q;
  assign cfg_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_packet_cutter_cfg_sched.sv
// Self-checking bench for packet_cutter_cfg_sched. A full-width instance and a
// 4-bit instance share the same stimulus; the narrow one exposes counter wrap.
module tb_packet_cutter_cfg_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        commit = 1'b0, ce_i = 1'b0, he_i = 1'b0;
  logic [31:0] w_i = '0, o_i = '0, b_i = '0;
  logic        tv_i = 1'b0, tl_i = 1'b0, tr_i = 1'b0;

  logic        tr_o, tv_o, ce_o, he_o, busy_o, appl_o;
  logic [31:0] w_o, o_o, b_o, cnt_o;

  logic [3:0]  w2_i, o2_i, b2_i;
  logic        tr2_o, tv2_o, ce2_o, he2_o, busy2_o, appl2_o;
  logic [3:0]  w2_o, o2_o, b2_o, cnt2_o;

  assign w2_i = w_i[3:0];
  assign o2_i = o_i[3:0];
  assign b2_i = b_i[3:0];

  always #5 clk = ~clk;

  packet_cutter_cfg_sched #(.C_S_AXI_DATA_WIDTH(32)) dut (
    .axi_aclk(clk), .axi_reset(rst), .cfg_commit(commit), .cfg_cut_en(ce_i),
    .cfg_cut_words(w_i), .cfg_cut_offset(o_i), .cfg_cut_bytes(b_i),
    .cfg_hash_en(he_i), .s_axis_tvalid_in(tv_i), .s_axis_tlast(tl_i),
    .s_axis_tready_out(tr_o), .s_axis_tvalid_out(tv_o), .s_axis_tready_in(tr_i),
    .cut_en(ce_o), .hash_en(he_o), .cut_words(w_o), .cut_offset(o_o),
    .cut_bytes(b_o), .cfg_busy(busy_o), .cfg_applied(appl_o), .apply_cnt(cnt_o)
  );

  packet_cutter_cfg_sched #(.C_S_AXI_DATA_WIDTH(4)) dut4 (
    .axi_aclk(clk), .axi_reset(rst), .cfg_commit(commit), .cfg_cut_en(ce_i),
    .cfg_cut_words(w2_i), .cfg_cut_offset(o2_i), .cfg_cut_bytes(b2_i),
    .cfg_hash_en(he_i), .s_axis_tvalid_in(tv_i), .s_axis_tlast(tl_i),
    .s_axis_tready_out(tr2_o), .s_axis_tvalid_out(tv2_o), .s_axis_tready_in(tr_i),
    .cut_en(ce2_o), .hash_en(he2_o), .cut_words(w2_o), .cut_offset(o2_o),
    .cut_bytes(b2_o), .cfg_busy(busy2_o), .cfg_applied(appl2_o), .apply_cnt(cnt2_o)
  );

  int unsigned tests = 0;
  int unsigned fails = 0;

  // Reference model: a pending-commit flag, an "update happens now" flag,
  // packet position, and the shadow/active settings as plain variables.
  bit          m_pend, m_apply, m_inpkt, m_applied;
  bit          s_ce, s_he, a_ce, a_he;
  logic [31:0] s_w, s_o, s_b, a_w, a_o, a_b, m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_apply = 0; m_inpkt = 0; m_applied = 0;
    s_ce = 0; s_he = 0; a_ce = 0; a_he = 0;
    s_w = '0; s_o = '0; s_b = '0; a_w = '0; a_o = '0; a_b = '0; m_cnt = '0;
  endtask

  task automatic check_outputs();
    chk("tvalid_out", {31'b0, tv_o}, {31'b0, m_apply ? 1'b0 : tv_i});
    chk("tready_out", {31'b0, tr_o}, {31'b0, m_apply ? 1'b0 : tr_i});
    chk("busy",       {31'b0, busy_o}, {31'b0, m_pend | m_apply});
    chk("applied",    {31'b0, appl_o}, {31'b0, m_applied});
    chk("apply_cnt",  cnt_o, m_cnt);
    chk("cut_words",  w_o, a_w);
    chk("cut_offset", o_o, a_o);
    chk("cut_bytes",  b_o, a_b);
    chk("cut_en",     {31'b0, ce_o}, {31'b0, a_ce});
    chk("hash_en",    {31'b0, he_o}, {31'b0, a_he});
    chk("w4_cnt",     {28'b0, cnt2_o}, {28'b0, m_cnt[3:0]});
    chk("w4_words",   {28'b0, w2_o}, {28'b0, a_w[3:0]});
    chk("w4_tvalid",  {31'b0, tv2_o}, {31'b0, m_apply ? 1'b0 : tv_i});
  endtask

  // One clock cycle: drive, check at the falling edge, advance the model.
  task automatic step(input bit c, input logic [31:0] w, input logic [31:0] o,
                      input logic [31:0] b, input bit ce, input bit he,
                      input bit tv, input bit tl, input bit tr);
    bit beat, lastb, nx_apply, nx_pend;
    commit = c; w_i = w; o_i = o; b_i = b; ce_i = ce; he_i = he;
    tv_i = tv; tl_i = tl; tr_i = tr;
    @(negedge clk);
    check_outputs();
    beat  = !m_apply && tv && tr;
    lastb = beat && tl;
    if (m_apply)     nx_apply = c;
    else if (m_pend) nx_apply = lastb;
    else             nx_apply = c && (!m_inpkt || lastb);
    nx_pend = !m_apply && !nx_apply && (m_pend || c);
    m_applied = m_apply;
    if (m_apply) begin
      a_ce = s_ce; a_he = s_he; a_w = s_w; a_o = s_o; a_b = s_b;
      m_cnt = m_cnt + 32'd1;
    end
    if (c) begin
      s_ce = ce; s_he = he; s_w = w; s_o = o; s_b = b;
    end
    if (beat) m_inpkt = !tl;
    m_apply = nx_apply;
    m_pend  = nx_pend;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) step(0, '0, '0, '0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    model_reset();
    #12;
    chk("rst_busy", {31'b0, busy_o}, 32'd0);
    chk("rst_cnt", cnt_o, 32'd0);
    chk("rst_words", w_o, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // Commit on an idle stream: update next cycle, visible the one after.
    step(1, 32'd4, 32'd2, 32'd64, 1, 0, 0, 0, 1);
    chk("d16_gate_busy", {31'b0, busy_o}, 32'd1);
    step(0, '0, '0, '0, 0, 0, 1, 0, 1);
    chk("d16_words", w_o, 32'd4);
    chk("d16_applied", {31'b0, appl_o}, 32'd1);
    chk("d16_cnt", cnt_o, 32'd1);
    idle(1);

    // Commit after the first beat of a 5-beat packet waits for the tlast beat.
    step(0, '0, '0, '0, 0, 0, 1, 0, 1);
    step(1, 32'd9, 32'd1, 32'd16, 0, 1, 1, 0, 1);
    step(0, '0, '0, '0, 0, 0, 1, 0, 1);
    chk("d17_hold", w_o, 32'd4);
    step(0, '0, '0, '0, 0, 0, 1, 0, 1);
    step(0, '0, '0, '0, 0, 0, 1, 1, 1);
    chk("d17_still_old", w_o, 32'd4);
    step(0, '0, '0, '0, 0, 0, 1, 0, 1);
    idle(1);
    chk("d17_new", w_o, 32'd9);

    // Two commits while waiting: only the later one is applied, once.
    step(0, '0, '0, '0, 0, 0, 1, 0, 1);
    step(1, 32'd3, 32'd0, 32'd0, 1, 0, 1, 0, 1);
    step(1, 32'd7, 32'd0, 32'd0, 1, 0, 1, 0, 1);
    step(0, '0, '0, '0, 0, 0, 1, 1, 1);
    step(0, '0, '0, '0, 0, 0, 0, 0, 1);
    idle(1);
    chk("d18_words", w_o, 32'd7);
    chk("d18_cnt", cnt_o, 32'd3);

    // Commit coinciding with the tlast beat goes straight to the update.
    step(0, '0, '0, '0, 0, 0, 1, 0, 1);
    step(1, 32'd5, 32'd0, 32'd0, 0, 0, 1, 1, 1);
    chk("d19_direct", {31'b0, tv_o}, 32'd0);
    idle(2);

    // Commit during the update cycle gives back-to-back updates.
    step(1, 32'd11, '0, '0, 0, 0, 0, 0, 1);
    step(1, 32'd12, '0, '0, 0, 0, 0, 0, 1);
    chk("d20_second_apply", {31'b0, busy_o}, 32'd1);
    idle(2);
    chk("d20_words", w_o, 32'd12);

    // Reset while waiting for end of packet discards the commit.
    step(0, '0, '0, '0, 0, 0, 1, 0, 1);
    step(1, 32'd13, '0, '0, 1, 1, 1, 0, 1);
    commit = 0; tv_i = 0; tr_i = 0; tl_i = 0;
    #2 rst = 1'b1;
    #1;
    chk("d21_busy", {31'b0, busy_o}, 32'd0);
    chk("d21_words", w_o, 32'd0);
    chk("d21_cnt", cnt_o, 32'd0);
    chk("d21_tvalid", {31'b0, tv_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    model_reset();
    idle(3);
    step(1, 32'd2, '0, '0, 0, 0, 0, 0, 1);
    chk("d21_fresh_apply", {31'b0, busy_o}, 32'd1);
    idle(2);

    // Randomized traffic and commits; the 4-bit instance wraps many times.
    for (int unsigned k = 0; k < 600; k++) begin
      step(($urandom_range(0, 5) == 0), $urandom, $urandom, $urandom,
           $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 4) != 0);
    end
    idle(3);
    chk("wrap_w4", {28'b0, cnt2_o}, {28'b0, m_cnt[3:0]});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
